// File: rtl/mono_filter_pkg.sv
// Shared constants for the monochrome video filter: mode encodings,
// luma coefficients and the 2x2 ordered-dither table.
package mono_filter_pkg;

    typedef enum logic [1:0] {
        MODE_COLOUR = 2'b00,
        MODE_GREEN  = 2'b01,
        MODE_AMBER  = 2'b10,
        MODE_GREY   = 2'b11
    } mode_t;

    localparam int LUMA_CR  = 54;
    localparam int LUMA_CG  = 183;
    localparam int LUMA_CB  = 19;
    localparam int LUMA_RND = 128;

    // Entries indexed by {y_parity, x_parity}: 0, 2, 3, 1
    localparam logic [7:0] BAYER = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic logic [1:0] bayer(input logic [1:0] yx);
        return BAYER[{yx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/mono_pixel_filter_if.sv
// Pixel bundle (colour channels plus syncs and display enable).
interface mono_pixel_filter_if #(parameter int W = 6);
    logic [W-1:0] r;
    logic [W-1:0] g;
    logic [W-1:0] b;
    logic         hs;
    logic         vs;
    logic         de;

    modport master (output r, g, b, hs, vs, de);
    modport slave  (input  r, g, b, hs, vs, de);
endinterface

// File: rtl/mono_luma.sv
// Two-stage luma datapath: registered coefficient products, then rounded sum.
module mono_luma
    import mono_filter_pkg::*;
#(
    parameter int IN_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [IN_W-1:0] r,
    input  logic [IN_W-1:0] g,
    input  logic [IN_W-1:0] b,
    output logic [IN_W-1:0] y
);
    localparam int PW = IN_W + 8;
    localparam int SW = IN_W + 10;

    logic [PW-1:0] p_r;
    logic [PW-1:0] p_g;
    logic [PW-1:0] p_b;
    logic [SW-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_r <= '0;
            p_g <= '0;
            p_b <= '0;
        end else if (ce) begin
            p_r <= PW'(r) * PW'(LUMA_CR);
            p_g <= PW'(g) * PW'(LUMA_CG);
            p_b <= PW'(b) * PW'(LUMA_CB);
        end
    end

    always_comb begin
        sum = SW'(p_r) + SW'(p_g) + SW'(p_b) + SW'(LUMA_RND);
    end

    // Coefficients sum to 256, so the shifted result always fits IN_W bits
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (ce) begin
            y <= IN_W'(sum >> 8);
        end
    end

endmodule

// File: rtl/mono_pixel_filter.sv
// Colour-to-monochrome pixel filter: frame-synchronous mode latch, luma,
// ordered dither on truncation, blanking and a matching sync delay line.
module mono_pixel_filter
    import mono_filter_pkg::*;
#(
    parameter int IN_W     = 6,
    parameter int OUT_W    = 3,
    parameter bit DITHER   = 1'b1,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [1:0]          mode_sel,
    mono_pixel_filter_if.slave  pix_in,
    mono_pixel_filter_if.master pix_out,
    output logic [1:0]          mode_active
);
    localparam int D       = IN_W - OUT_W;
    localparam bit DITH_ON = DITHER && (D >= 2);
    localparam int SH      = DITH_ON ? D - 2 : 0;
    localparam logic [2:0] SYNC_IDLE = {~SYNC_ACT, ~SYNC_ACT, 1'b0};

    logic            vs_prev, de_prev, x_par, y_par;
    logic            vs_edge, de_fall;
    logic [IN_W-1:0] y;
    logic [IN_W-1:0] r_d1, g_d1, b_d1, r_d2, g_d2, b_d2;
    logic [2:0]      sync_d1, sync_d2;
    logic [1:0]      bay_d1, bay_d2;
    logic [IN_W-1:0] m_r, m_g, m_b;
    logic [OUT_W-1:0] q_r, q_g, q_b;

    assign vs_edge = (pix_in.vs == SYNC_ACT) && (vs_prev != SYNC_ACT);
    assign de_fall = de_prev && !pix_in.de;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev     <= ~SYNC_ACT;
            de_prev     <= 1'b0;
            x_par       <= 1'b0;
            y_par       <= 1'b0;
            mode_active <= MODE_COLOUR;
        end else if (ce) begin
            vs_prev <= pix_in.vs;
            de_prev <= pix_in.de;
            if (vs_edge) mode_active <= mode_sel;
            if (de_fall) x_par <= 1'b0;
            else if (pix_in.de) x_par <= ~x_par;
            // Frame start takes priority over the line-end toggle
            if (vs_edge) y_par <= 1'b0;
            else if (de_fall) y_par <= ~y_par;
        end
    end

    mono_luma #(.IN_W(IN_W)) u_luma (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .r   (pix_in.r),
        .g   (pix_in.g),
        .b   (pix_in.b),
        .y   (y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_d1, g_d1, b_d1} <= '0;
            {r_d2, g_d2, b_d2} <= '0;
            sync_d1 <= SYNC_IDLE;
            sync_d2 <= SYNC_IDLE;
            bay_d1  <= '0;
            bay_d2  <= '0;
        end else if (ce) begin
            {r_d1, g_d1, b_d1} <= {pix_in.r, pix_in.g, pix_in.b};
            {r_d2, g_d2, b_d2} <= {r_d1, g_d1, b_d1};
            sync_d1 <= {pix_in.hs, pix_in.vs, pix_in.de};
            sync_d2 <= sync_d1;
            bay_d1  <= bayer({y_par, x_par});
            bay_d2  <= bay_d1;
        end
    end

    function automatic logic [OUT_W-1:0] trunc(input logic [IN_W-1:0] v, input logic [1:0] bv);
        logic [IN_W:0] s;
        s = DITH_ON ? ({1'b0, v} + ((IN_W+1)'(bv) << SH)) : {1'b0, v};
        if (s[IN_W]) s = {1'b0, {IN_W{1'b1}}};
        return OUT_W'(s[IN_W-1:0] >> D);
    endfunction

    always_comb begin
        m_r = r_d2;
        m_g = g_d2;
        m_b = b_d2;
        case (mode_active)
            MODE_GREEN: begin m_r = '0; m_g = y;      m_b = '0; end
            MODE_AMBER: begin m_r = y;  m_g = y >> 1; m_b = '0; end
            MODE_GREY:  begin m_r = y;  m_g = y;      m_b = y;  end
            default:    ;
        endcase
        q_r = trunc(m_r, bay_d2);
        q_g = trunc(m_g, bay_d2);
        q_b = trunc(m_b, bay_d2);
        if (mode_active == MODE_GREEN) q_r = '0;
        if (mode_active == MODE_GREEN || mode_active == MODE_AMBER) q_b = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out.r  <= '0;
            pix_out.g  <= '0;
            pix_out.b  <= '0;
            pix_out.hs <= ~SYNC_ACT;
            pix_out.vs <= ~SYNC_ACT;
            pix_out.de <= 1'b0;
        end else if (ce) begin
            pix_out.r  <= sync_d2[0] ? q_r : '0;
            pix_out.g  <= sync_d2[0] ? q_g : '0;
            pix_out.b  <= sync_d2[0] ? q_b : '0;
            {pix_out.hs, pix_out.vs, pix_out.de} <= sync_d2;
        end
    end

endmodule
